scan_move_sequencer: RTL and testbench

- Sequences the cube-manipulation moves the robot needs during colour scanning.
- Each request carries a sticker-observation number (0..48). The block issues the required move list to the motor driver one move at a time, with a handshake, and waits for each move to finish.
- After a mechanical settle time it raises color_sensor_stable for the state-determination FSM.
- It sits between the state-determination FSM (send_setup_moves, counter) and the motor driver.

---
 rtl/scan_move_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_scan_move_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_move_sequencer.sv
// scan_move_sequencer: issues the cube moves needed between colour-scan
// observations to the motor driver, one handshaked move at a time. After a
// mechanical settle period it reports the colour sensors as stable.
module scan_move_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STEPS         = 48
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_setup_moves,
  input  logic [5:0] counter,
  output logic       move_valid,
  output logic [4:0] move_code,
  input  logic       move_ready,
  input  logic       motor_done,
  output logic       color_sensor_stable,
  output logic       busy,
  output logic       scan_restored,
  output logic       bad_request
);

  localparam logic [5:0]  STEPS_C  = 6'(STEPS);
  localparam logic [15:0] SETTLE_C = 16'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    SETTLE    = 3'd3,
    STABLE    = 3'd4,
    CLOSED    = 3'd5
  } state_t;

  // Number of moves in the entry sequence of group g.
  function automatic logic [3:0] entry_len(input logic [3:0] g);
    case (g)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: entry_len = 4'd2;
      4'd7, 4'd8, 4'd9, 4'd10:      entry_len = 4'd6;
      4'd11:                        entry_len = 4'd4;
      default:                      entry_len = 4'd0;
    endcase
  endfunction

  // Entry sequence of group g, first move in the low five bits.
  function automatic logic [29:0] entry_seq(input logic [3:0] g);
    case (g)
      4'd1:    entry_seq = {20'd0, 5'b10010, 5'b01001};
      4'd2:    entry_seq = {20'd0, 5'b01101, 5'b00110};
      4'd3:    entry_seq = {20'd0, 5'b10001, 5'b01010};
      4'd4:    entry_seq = {20'd0, 5'b01110, 5'b00101};
      4'd5:    entry_seq = {20'd0, 5'b01111, 5'b00111};
      4'd7:    entry_seq = {5'b10010, 5'b01001, 5'b00001, 5'b00101, 5'b10010, 5'b01001};
      4'd8:    entry_seq = {5'b01101, 5'b00110, 5'b00010, 5'b01001, 5'b01101, 5'b00110};
      4'd9:    entry_seq = {5'b10001, 5'b01010, 5'b00001, 5'b01101, 5'b10001, 5'b01010};
      4'd10:   entry_seq = {5'b01110, 5'b00101, 5'b00001, 5'b10010, 5'b01110, 5'b00101};
      4'd11:   entry_seq = {10'd0, 5'b10011, 5'b01011, 5'b00111, 5'b01111};
      default: entry_seq = 30'd0;
    endcase
  endfunction

  // Move k of the entry sequence of group g.
  function automatic logic [4:0] entry_move(input logic [3:0] g, input logic [3:0] k);
    logic [29:0] sh;
    sh = entry_seq(g) >> ({1'b0, k} * 5'd5);
    entry_move = sh[4:0];
  endfunction

  // Inverse turn: CW and CCW swap, half turn unchanged.
  function automatic logic [4:0] invert_move(input logic [4:0] m);
    invert_move = {m[4:2], m[0], m[1]};
  endfunction

  // Total move-list length for request c: U CW, then exit, then entry.
  function automatic logic [3:0] list_len(input logic [5:0] c);
    logic       has_u;
    logic       div;
    logic [3:0] g;
    logic [3:0] exl;
    logic [3:0] enl;
    has_u = (c != 6'd0);
    div   = (c[1:0] == 2'b00);
    g     = c[5:2];
    exl   = (div && has_u) ? entry_len(g - 4'd1) : 4'd0;
    enl   = (div && (c < STEPS_C)) ? entry_len(g) : 4'd0;
    list_len = {3'b000, has_u} + exl + enl;
  endfunction

  // Move idx of the list for request c.
  function automatic logic [4:0] move_at(input logic [5:0] c, input logic [3:0] idx);
    logic       has_u;
    logic       div;
    logic [3:0] g;
    logic [3:0] exl;
    logic [3:0] j;
    has_u = (c != 6'd0);
    div   = (c[1:0] == 2'b00);
    g     = c[5:2];
    exl   = (div && has_u) ? entry_len(g - 4'd1) : 4'd0;
    j     = idx - {3'b000, has_u};
    if (has_u && (idx == 4'd0)) begin
      move_at = 5'b00001;
    end else if (j < exl) begin
      move_at = invert_move(entry_move(g - 4'd1, exl - 4'd1 - j));
    end else begin
      move_at = entry_move(g, j - exl);
    end
  endfunction

  state_t      state_r, state_s;
  logic [5:0]  c_r, c_s;
  logic [3:0]  idx_r, idx_s;
  logic [15:0] cnt_r, cnt_s;
  logic        valid_r, valid_s;
  logic [4:0]  code_r, code_s;
  logic        stable_r, stable_s;
  logic        busy_r, busy_s;
  logic        restored_r, restored_s;
  logic        bad_r, bad_s;

  logic        idle_like_s;
  logic        accept_s;
  logic [3:0]  len_in_s;
  logic [3:0]  len_cur_s;
  logic [4:0]  first_move_s;
  logic [4:0]  next_move_s;

  assign idle_like_s  = (state_r == IDLE) || (state_r == STABLE);
  assign accept_s     = send_setup_moves && idle_like_s && (counter <= STEPS_C);
  assign len_in_s     = list_len(counter);
  assign len_cur_s    = list_len(c_r);
  assign first_move_s = move_at(counter, 4'd0);
  assign next_move_s  = move_at(c_r, idx_r + 4'd1);

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_s    = state_r;
    c_s        = c_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    valid_s    = valid_r;
    code_s     = code_r;
    stable_s   = stable_r;
    busy_s     = busy_r;
    restored_s = restored_r;
    // Busy states swallow strobes silently; CLOSED and out-of-range are flagged.
    if (send_setup_moves && ((state_r == CLOSED) || (idle_like_s && (counter > STEPS_C)))) begin
      bad_s = 1'b1;
    end else begin
      bad_s = 1'b0;
    end
    case (state_r)
      IDLE, STABLE: begin
        if (accept_s) begin
          c_s      = counter;
          idx_s    = 4'd0;
          cnt_s    = 16'd0;
          stable_s = 1'b0;
          busy_s   = 1'b1;
          if (len_in_s != 4'd0) begin
            state_s = ISSUE;
            valid_s = 1'b1;
            code_s  = first_move_s;
          end else begin
            state_s = SETTLE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ISSUE: begin
        if (move_ready) begin
          state_s = WAIT_DONE;
          valid_s = 1'b0;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (motor_done) begin
          if ((idx_r + 4'd1) < len_cur_s) begin
            state_s = ISSUE;
            idx_s   = idx_r + 4'd1;
            valid_s = 1'b1;
            code_s  = next_move_s;
          end else if (c_r == STEPS_C) begin
            state_s    = CLOSED;
            restored_s = 1'b1;
            busy_s     = 1'b0;
          end else begin
            state_s = SETTLE;
            cnt_s   = 16'd0;
          end
        end else begin
          state_s = WAIT_DONE;
        end
      end
      SETTLE: begin
        if (cnt_r >= SETTLE_C) begin
          state_s  = STABLE;
          stable_s = 1'b1;
          busy_s   = 1'b0;
        end else if (cnt_r != 16'hFFFF) begin
          cnt_s = cnt_r + 16'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      CLOSED: begin
        state_s = CLOSED;
      end
      default: begin
        state_s    = IDLE;
        valid_s    = 1'b0;
        stable_s   = 1'b0;
        busy_s     = 1'b0;
        restored_s = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      c_r        <= 6'd0;
      idx_r      <= 4'd0;
      cnt_r      <= 16'd0;
      valid_r    <= 1'b0;
      code_r     <= 5'd0;
      stable_r   <= 1'b0;
      busy_r     <= 1'b0;
      restored_r <= 1'b0;
      bad_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      c_r        <= c_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      valid_r    <= valid_s;
      code_r     <= code_s;
      stable_r   <= stable_s;
      busy_r     <= busy_s;
      restored_r <= restored_s;
      bad_r      <= bad_s;
    end
  end

  assign move_valid          = valid_r;
  assign move_code           = code_r;
  assign color_sensor_stable = stable_r;
  assign busy                = busy_r;
  assign scan_restored       = restored_r;
  assign bad_request         = bad_r;

endmodule

// File: tb/tb_scan_move_sequencer.sv
// Testbench for scan_move_sequencer: directed and randomized requests checked
// against a move-list model built from the face/turn tables.
module tb_scan_move_sequencer;

  localparam int SP    = 4;
  localparam int STEPS = 48;
  localparam int U_F   = 0;
  localparam int CW    = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       send_setup_moves;
  logic [5:0] counter;
  logic       move_valid;
  logic [4:0] move_code;
  logic       move_ready;
  logic       motor_done;
  logic       color_sensor_stable;
  logic       busy;
  logic       scan_restored;
  logic       bad_request;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  // Faces U0 L1 F2 R3 B4 D5; turns 1=CW 2=CCW 3=half.
  int ent_len [12] = '{0, 2, 2, 2, 2, 2, 0, 6, 6, 6, 6, 4};
  int ent_face [12][6] = '{
    '{0,0,0,0,0,0}, '{2,4,0,0,0,0}, '{1,3,0,0,0,0}, '{2,4,0,0,0,0},
    '{1,3,0,0,0,0}, '{1,3,0,0,0,0}, '{0,0,0,0,0,0}, '{2,4,1,0,2,4},
    '{1,3,2,0,1,3}, '{2,4,3,0,2,4}, '{1,3,4,0,1,3}, '{3,1,2,4,0,0}};
  int ent_turn [12][6] = '{
    '{0,0,0,0,0,0}, '{1,2,0,0,0,0}, '{2,1,0,0,0,0}, '{2,1,0,0,0,0},
    '{1,2,0,0,0,0}, '{3,3,0,0,0,0}, '{0,0,0,0,0,0}, '{1,2,1,1,1,2},
    '{2,1,1,2,2,1}, '{2,1,1,1,2,1}, '{1,2,2,1,1,2}, '{3,3,3,3,0,0}};

  scan_move_sequencer #(.SETTLE_CYCLES(SP), .STEPS(STEPS)) dut (
    .clock               (clock),
    .reset               (reset),
    .send_setup_moves    (send_setup_moves),
    .counter             (counter),
    .move_valid          (move_valid),
    .move_code           (move_code),
    .move_ready          (move_ready),
    .motor_done          (motor_done),
    .color_sensor_stable (color_sensor_stable),
    .busy                (busy),
    .scan_restored       (scan_restored),
    .bad_request         (bad_request)
  );

  always #5 clock = ~clock;

  function automatic int inv_turn(input int t);
    return (t == 1) ? 2 : ((t == 2) ? 1 : t);
  endfunction

  task automatic build(input int c);
    int g;
    exp_q.delete();
    g = c / 4;
    if (c > 0) exp_q.push_back(5'(U_F * 4 + CW));
    if ((c % 4 == 0) && (c > 0))
      for (int k = ent_len[g-1] - 1; k >= 0; k--)
        exp_q.push_back(5'(ent_face[g-1][k] * 4 + inv_turn(ent_turn[g-1][k])));
    if ((c % 4 == 0) && (c < STEPS))
      for (int k = 0; k < ent_len[g]; k++)
        exp_q.push_back(5'(ent_face[g][k] * 4 + ent_turn[g][k]));
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    16'(move_valid), 16'd0);
    chk({tag, "_code"},     16'(move_code), 16'd0);
    chk({tag, "_stable"},   16'(color_sensor_stable), 16'd0);
    chk({tag, "_busy"},     16'(busy), 16'd0);
    chk({tag, "_restored"}, 16'(scan_restored), 16'd0);
    chk({tag, "_bad"},      16'(bad_request), 16'd0);
  endtask

  // One full request: accept, every move with stalls/gaps, then settle or close.
  task automatic req(input int c, input int stall_force);
    int stall;
    int gap;
    build(c);
    send_setup_moves = 1'b1;
    counter = 6'(c);
    step();
    send_setup_moves = 1'b0;
    chk("accept_busy", 16'(busy), 16'd1);
    chk("accept_stable", 16'(color_sensor_stable), 16'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("move_valid", 16'(move_valid), 16'd1);
      chk("move_code", 16'(move_code), 16'(exp_q[i]));
      stall = (stall_force >= 0) ? stall_force : int'($urandom_range(0, 3));
      move_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_valid", 16'(move_valid), 16'd1);
        chk("stall_code", 16'(move_code), 16'(exp_q[i]));
      end
      move_ready = 1'b1;
      step();
      move_ready = 1'b0;
      chk("handshake_drop", 16'(move_valid), 16'd0);
      gap = int'($urandom_range(0, 4));
      for (int s = 0; s < gap; s++) begin
        send_setup_moves = ($urandom_range(0, 1) == 1);
        counter = 6'($urandom_range(0, 48));
        motor_done = 1'b0;
        step();
        send_setup_moves = 1'b0;
        chk("wait_valid", 16'(move_valid), 16'd0);
        chk("busy_no_bad", 16'(bad_request), 16'd0);
      end
      motor_done = 1'b1;
      step();
      motor_done = 1'b0;
    end
    if (c == STEPS) begin
      chk("close_restored", 16'(scan_restored), 16'd1);
      chk("close_busy", 16'(busy), 16'd0);
      chk("close_stable", 16'(color_sensor_stable), 16'd0);
      chk("close_valid", 16'(move_valid), 16'd0);
    end else begin
      for (int k = 0; k <= SP; k++) begin
        chk("settle_stable", 16'(color_sensor_stable), 16'd0);
        chk("settle_busy", 16'(busy), 16'd1);
        chk("settle_valid", 16'(move_valid), 16'd0);
        step();
      end
      chk("stable_rise", 16'(color_sensor_stable), 16'd1);
      chk("stable_busy", 16'(busy), 16'd0);
    end
  endtask

  // Rejected strobe: one-cycle bad_request pulse, nothing else changes.
  task automatic bad_strobe(input int c, input logic exp_stable, input logic exp_restored);
    send_setup_moves = 1'b1;
    counter = 6'(c);
    step();
    send_setup_moves = 1'b0;
    chk("bad_pulse", 16'(bad_request), 16'd1);
    chk("bad_busy", 16'(busy), 16'd0);
    chk("bad_valid", 16'(move_valid), 16'd0);
    step();
    chk("bad_pulse_end", 16'(bad_request), 16'd0);
    chk("bad_keep_stable", 16'(color_sensor_stable), 16'(exp_stable));
    chk("bad_keep_restored", 16'(scan_restored), 16'(exp_restored));
  endtask

  initial begin
    reset = 1'b1;
    send_setup_moves = 1'b0;
    counter = 6'd0;
    move_ready = 1'b0;
    motor_done = 1'b0;
    #2;
    chk_all_zero("reset");
    step();
    step();
    reset = 1'b0;
    step();
    chk_all_zero("idle");

    bad_strobe(50, 1'b0, 1'b0);
    req(0, -1);
    req(1, 0);
    req(4, 3);
    req(28, -1);

    for (int k = 0; k < 3; k++) begin
      step();
      chk("stable_hold", 16'(color_sensor_stable), 16'd1);
    end
    bad_strobe(63, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) req(int'($urandom_range(1, 47)), -1);

    // Reset in the middle of ISSUE.
    send_setup_moves = 1'b1;
    counter = 6'd28;
    step();
    send_setup_moves = 1'b0;
    chk("pre_reset_valid", 16'(move_valid), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 16'(move_valid), 16'd0);
    chk("async_reset_busy", 16'(busy), 16'd0);
    step();
    step();
    reset = 1'b0;
    chk_all_zero("post_reset");
    req(0, -1);
    req(4, -1);
    req(8, -1);

    req(48, -1);
    bad_strobe(0, 1'b0, 1'b1);
    bad_strobe(12, 1'b0, 1'b1);

    reset = 1'b1;
    #1;
    chk_all_zero("final_reset");
    step();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
